// File: rtl/tx_pkg.sv
`default_nettype none
// ============================================================================
// Package    : tx_pkg
// Description: Shared types and constants for the transmit pulse scheduler.
// Revision   : 1.0 - initial release
// ============================================================================
package tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // First field lands in the MSBs, so a flat concatenation of the raw
    // register inputs in this order maps straight onto the struct.
    typedef struct packed {
        logic [31:0] phase;
        logic [31:0] period;
        logic [31:0] prt;
        logic [31:0] codigo;
        logic [31:0] numdig;
        logic [31:0] tb;
    } cfg_t;

    localparam logic [31:0] MAX_NUMDIG = 32'd32;

endpackage
`default_nettype wire

// File: rtl/tx_cfg_check.sv
`default_nettype none
// ============================================================================
// Module     : tx_cfg_check
// Description: Combinational waveform-configuration validity check.
// Revision   : 1.0 - initial release
// ============================================================================
module tx_cfg_check
    import tx_pkg::*;
(
    input  cfg_t cfg,
    output logic valid
);

    logic [37:0] code_len;
    logic        unused_fields;

    // Coded pulse length in clocks must fit inside the pulse period.
    assign code_len      = {32'd0, cfg.numdig[5:0]} * {6'd0, cfg.tb};
    assign unused_fields = ^{cfg.phase, cfg.codigo};

    always_comb begin
        valid = (cfg.period != 32'd0)
             && (cfg.prt > cfg.period)
             && (cfg.numdig != 32'd0)
             && (cfg.numdig <= MAX_NUMDIG)
             && (cfg.tb != 32'd0)
             && (code_len <= {6'd0, cfg.period});
    end

endmodule
`default_nettype wire

// File: rtl/tx_sched.sv
`default_nettype none
// ============================================================================
// Module     : tx_sched
// Description: Pulse-train scheduler; shadows waveform config, swaps it only
//              in the inter-pulse gap, runs bursts, aborts cleanly.
// Revision   : 1.0 - initial release
// ============================================================================
module tx_sched
    import tx_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_arm,
    input  logic             i_abort,
    input  logic             i_cfg_update,
    input  logic [31:0]      i_phase,
    input  logic [31:0]      i_period,
    input  logic [31:0]      i_prt,
    input  logic [31:0]      i_codigo,
    input  logic [31:0]      i_numdig,
    input  logic [31:0]      i_tb,
    input  logic [CNT_W-1:0] i_num_pulses,
    input  logic             i_sinc,
    output logic             o_start,
    output logic [31:0]      o_phase,
    output logic [31:0]      o_period,
    output logic [31:0]      o_prt,
    output logic [31:0]      o_codigo,
    output logic [31:0]      o_numdig,
    output logic [31:0]      o_tb,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [CNT_W-1:0] o_pulse_cnt
);

    state_t             state, state_n;
    cfg_t               shadow, shadow_n;
    cfg_t               staging, staging_n;
    cfg_t               in_cfg;
    logic               pending, pending_n;
    logic [CNT_W-1:0]   cnt, cnt_n, cnt_inc;
    logic               err, err_n;
    logic               done, done_n;
    logic               start;
    logic               busy;
    logic               sinc_q;
    logic               pulse_end;
    logic               shadow_ok;
    logic               staging_ok;

    assign in_cfg    = {i_phase, i_period, i_prt, i_codigo, i_numdig, i_tb};
    assign pulse_end = sinc_q && !i_sinc;
    assign cnt_inc   = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;

    tx_cfg_check u_check_shadow (
        .cfg   (shadow),
        .valid (shadow_ok)
    );

    tx_cfg_check u_check_staging (
        .cfg   (staging),
        .valid (staging_ok)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state   <= IDLE;
            shadow  <= '0;
            staging <= '0;
            pending <= 1'b0;
            cnt     <= '0;
            err     <= 1'b0;
            done    <= 1'b0;
            start   <= 1'b0;
            busy    <= 1'b0;
            sinc_q  <= 1'b0;
        end else begin
            state   <= state_n;
            shadow  <= shadow_n;
            staging <= staging_n;
            pending <= pending_n;
            cnt     <= cnt_n;
            err     <= err_n;
            done    <= done_n;
            start   <= (state_n == RUN) || (state_n == DRAIN);
            busy    <= (state_n != IDLE);
            sinc_q  <= i_sinc;
        end
    end

    always_comb begin
        state_n   = state;
        shadow_n  = shadow;
        staging_n = staging;
        pending_n = pending;
        cnt_n     = cnt;
        err_n     = err;
        done_n    = 1'b0;

        case (state)
            IDLE: begin
                if (i_arm) begin
                    shadow_n  = in_cfg;
                    cnt_n     = '0;
                    err_n     = 1'b0;
                    pending_n = 1'b0;
                    state_n   = CHECK;
                end else if (i_cfg_update) begin
                    shadow_n = in_cfg;
                end
            end
            CHECK: begin
                if (!shadow_ok) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else if (i_abort) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    state_n = RUN;
                end
            end
            RUN: begin
                if (pulse_end) begin
                    cnt_n = cnt_inc;
                    if (pending) begin
                        if (staging_ok) shadow_n = staging;
                        else            err_n    = 1'b1;
                        pending_n = 1'b0;
                    end
                end
                // Terminal pulse end wins over a same-cycle abort.
                if (pulse_end && (i_num_pulses != '0) && (cnt_inc == i_num_pulses)) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else if (i_abort) begin
                    if (!i_sinc) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pulse_end) begin
                    cnt_n     = cnt_inc;
                    pending_n = 1'b0;
                    done_n    = 1'b1;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // Applied last so a same-cycle pulse end consumes the older staging.
        if ((state != IDLE) && (state_n != IDLE) && i_cfg_update) begin
            staging_n = in_cfg;
            pending_n = 1'b1;
        end
    end

    assign o_start     = start;
    assign o_phase     = shadow.phase;
    assign o_period    = shadow.period;
    assign o_prt       = shadow.prt;
    assign o_codigo    = shadow.codigo;
    assign o_numdig    = shadow.numdig;
    assign o_tb        = shadow.tb;
    assign o_busy      = busy;
    assign o_done      = done;
    assign o_err       = err;
    assign o_pulse_cnt = cnt;

endmodule
`default_nettype wire

// File: tb/tb_tx_sched.sv
`default_nettype none
// ============================================================================
// Module     : tb_tx_sched
// Description: Self-checking bench for tx_sched with a completion scoreboard.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_tx_sched;

    localparam int CNT_W = 16;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b0;
    logic             i_arm = 1'b0;
    logic             i_abort = 1'b0;
    logic             i_cfg_update = 1'b0;
    logic [31:0]      i_phase = '0, i_period = '0, i_prt = '0;
    logic [31:0]      i_codigo = '0, i_numdig = '0, i_tb = '0;
    logic [CNT_W-1:0] i_num_pulses = '0;
    logic             i_sinc = 1'b0;
    logic             o_start, o_busy, o_done, o_err;
    logic [31:0]      o_phase, o_period, o_prt, o_codigo, o_numdig, o_tb;
    logic [CNT_W-1:0] o_pulse_cnt;

    int checks = 0;
    int errors = 0;
    logic [CNT_W-1:0] done_q[$];

    always #5 i_clk = ~i_clk;

    tx_sched #(.CNT_W(CNT_W)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_arm        (i_arm),
        .i_abort      (i_abort),
        .i_cfg_update (i_cfg_update),
        .i_phase      (i_phase),
        .i_period     (i_period),
        .i_prt        (i_prt),
        .i_codigo     (i_codigo),
        .i_numdig     (i_numdig),
        .i_tb         (i_tb),
        .i_num_pulses (i_num_pulses),
        .i_sinc       (i_sinc),
        .o_start      (o_start),
        .o_phase      (o_phase),
        .o_period     (o_period),
        .o_prt        (o_prt),
        .o_codigo     (o_codigo),
        .o_numdig     (o_numdig),
        .o_tb         (o_tb),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err),
        .o_pulse_cnt  (o_pulse_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every o_done must match a completion the stimulus announced.
    always @(negedge i_clk) begin
        if (i_rst && o_done) begin
            if (done_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
            else                    check("done_cnt", 64'(o_pulse_cnt), 64'(done_q.pop_front()));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic set_cfg(input logic [31:0] ph, input logic [31:0] per, input logic [31:0] prt,
                           input logic [31:0] nd, input logic [31:0] tb, input logic [CNT_W-1:0] n);
        i_phase = ph; i_period = per; i_prt = prt; i_codigo = 32'hC0DE;
        i_numdig = nd; i_tb = tb; i_num_pulses = n;
    endtask

    task automatic arm_and_run;
        i_arm = 1'b1;
        step();
        i_arm = 1'b0;
        check("arm_busy", 64'(o_busy), 64'd1);
        check("arm_start_low", 64'(o_start), 64'd0);
        step();
        check("start_after_arm", 64'(o_start), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset values
        step(2);
        check("rst_start", 64'(o_start), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_period", 64'(o_period), 64'd0);
        check("rst_cnt", 64'(o_pulse_cnt), 64'd0);
        check("rst_err", 64'(o_err), 64'd0);
        @(negedge i_clk);
        i_rst = 1'b1;
        step(2);

        // Burst of three pulses
        set_cfg(32'h0, 32'd100, 32'd1000, 32'd13, 32'd5, 16'd3);
        done_q.push_back(16'd3);
        arm_and_run();
        check("burst_period", 64'(o_period), 64'd100);
        for (int p = 1; p <= 3; p++) begin
            i_sinc = 1'b1;
            step(4);
            i_sinc = 1'b0;
            step();
            check("burst_cnt", 64'(o_pulse_cnt), 64'(p));
            check("burst_start", 64'(o_start), (p == 3) ? 64'd0 : 64'd1);
            step(3);
        end
        check("burst_idle", 64'(o_busy), 64'd0);

        // Invalid configuration: prt not greater than period
        set_cfg(32'h0, 32'd100, 32'd100, 32'd13, 32'd5, 16'd3);
        i_arm = 1'b1;
        step();
        i_arm = 1'b0;
        check("inv_busy", 64'(o_busy), 64'd1);
        step();
        check("inv_err", 64'(o_err), 64'd1);
        check("inv_idle", 64'(o_busy), 64'd0);
        for (int k = 0; k < 4; k++) begin
            check("inv_no_start", 64'(o_start), 64'd0);
            step();
        end

        // Live update in continuous mode, then abort during sync low
        set_cfg(32'h0, 32'd100, 32'd1000, 32'd13, 32'd5, 16'd0);
        arm_and_run();
        check("live_err_cleared", 64'(o_err), 64'd0);
        i_sinc = 1'b1;
        step();
        i_cfg_update = 1'b1;
        i_phase = 32'h1000;
        step();
        i_cfg_update = 1'b0;
        check("live_phase_hold1", 64'(o_phase), 64'h0);
        step(2);
        check("live_phase_hold2", 64'(o_phase), 64'h0);
        i_sinc = 1'b0;
        step();
        check("live_phase_new", 64'(o_phase), 64'h1000);
        check("live_cnt", 64'(o_pulse_cnt), 64'd1);
        done_q.push_back(16'd1);
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        check("abort_low_idle", 64'(o_busy), 64'd0);
        check("abort_low_start", 64'(o_start), 64'd0);
        step(2);

        // Bad staged update, then abort during sync high
        set_cfg(32'h0, 32'd100, 32'd1000, 32'd13, 32'd5, 16'd0);
        arm_and_run();
        i_sinc = 1'b1;
        step();
        i_cfg_update = 1'b1;
        i_numdig = 32'd40;
        step();
        i_cfg_update = 1'b0;
        i_numdig = 32'd13;
        check("bad_upd_err_pre", 64'(o_err), 64'd0);
        i_sinc = 1'b0;
        step();
        check("bad_upd_err", 64'(o_err), 64'd1);
        check("bad_upd_numdig", 64'(o_numdig), 64'd13);
        check("bad_upd_running", 64'(o_start), 64'd1);
        step(2);
        done_q.push_back(16'd2);
        i_sinc = 1'b1;
        step();
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        check("drain_start", 64'(o_start), 64'd1);
        step(2);
        check("drain_busy", 64'(o_busy), 64'd1);
        i_sinc = 1'b0;
        step();
        check("drain_end_start", 64'(o_start), 64'd0);
        check("drain_end_cnt", 64'(o_pulse_cnt), 64'd2);
        step(2);

        // Abort in the check cycle
        set_cfg(32'h0, 32'd100, 32'd1000, 32'd13, 32'd5, 16'd4);
        done_q.push_back(16'd0);
        i_arm = 1'b1;
        step();
        i_arm = 1'b0;
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        check("chk_abort_idle", 64'(o_busy), 64'd0);
        check("chk_abort_start", 64'(o_start), 64'd0);
        step(2);

        // Asynchronous reset mid-run, then a fresh burst
        set_cfg(32'h7, 32'd100, 32'd1000, 32'd13, 32'd5, 16'd5);
        arm_and_run();
        i_sinc = 1'b1;
        step();
        #2;
        i_rst = 1'b0;
        #1;
        check("arst_start", 64'(o_start), 64'd0);
        check("arst_busy", 64'(o_busy), 64'd0);
        check("arst_phase", 64'(o_phase), 64'd0);
        check("arst_period", 64'(o_period), 64'd0);
        i_sinc = 1'b0;
        step(2);
        #2;
        i_rst = 1'b1;
        step(2);
        set_cfg(32'h0, 32'd100, 32'd1000, 32'd13, 32'd5, 16'd2);
        done_q.push_back(16'd2);
        arm_and_run();
        for (int p = 1; p <= 2; p++) begin
            i_sinc = 1'b1;
            step(3);
            i_sinc = 1'b0;
            step(3);
        end
        check("post_rst_cnt", 64'(o_pulse_cnt), 64'd2);
        check("post_rst_idle", 64'(o_busy), 64'd0);

        step(3);
        check("done_queue_empty", 64'(done_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tx_sched.md
# tx_sched

Pulse-train scheduler for the HF surface-wave radar transmitter. It sits between the register memory and the transmit datapath (sync generator, code generator, DDS, mixer). It drives the sync generator's start, and feeds every datapath stage from one shadow copy of the waveform configuration. New configuration is applied only in the inter-pulse gap, so no pulse ever mixes old and new parameters. It also runs finite bursts of N pulses, supports a clean abort, and rejects invalid configurations.

## Interface
Parameters:
- CNT_W, 16, pulse counter width.

Ports:
- i_clk  in  1  ADC-derived system clock; the same clock as the sync/code/DDS blocks.
- i_rst  in  1  Reset. Asynchronous assert, active-low.
- i_arm  in  1  Single-cycle pulse: latch the inputs and start a burst.
- i_abort  in  1  Single-cycle pulse: stop after the current pulse completes.
- i_cfg_update  in  1  Single-cycle pulse: latch the inputs into staging for the next gap.
- i_phase, i_period, i_prt, i_codigo, i_numdig, i_tb  in  32 each  Raw register values.
- i_num_pulses  in  CNT_W  Burst length; 0 means continuous.
- i_sinc  in  1  Sync level from the sync generator, synchronous to i_clk.
- o_start  out  1  Start to the sync generator.
- o_phase, o_period, o_prt, o_codigo, o_numdig, o_tb  out  32 each  Shadow configuration.
- o_busy  out  1  High in every state except IDLE.
- o_done  out  1  One-cycle pulse when a burst ends (normal completion or abort).
- o_err  out  1  Sticky. Set on a rejected config; cleared by the next i_arm.
- o_pulse_cnt  out  CNT_W  Completed pulses in the current burst.

## Operation
- Validity function V(cfg), all conditions required:
  - period ≥ 1 and prt > period;
  - 1 ≤ numdig ≤ 32;
  - tb ≥ 1;
  - numdig[5:0]·tb ≤ period, computed at 38 bits with period zero-extended.
- Pulse end is the falling edge of i_sinc, detected as registered sample = 1 and current i_sinc = 0.
- IDLE:
  - o_start = 0.
  - On i_arm: copy the inputs to the shadow, clear the counter, clear o_err, clear pending, go to CHECK.
  - i_cfg_update in IDLE copies the inputs directly to the shadow.
- CHECK (one cycle):
  - If V(shadow) fails: set o_err, go to IDLE, no o_done.
  - Else if i_abort: go to IDLE with o_done.
  - Else go to RUN.
- RUN: o_start = 1. On each pulse end:
  - Increment the counter. It saturates at all-ones when i_num_pulses = 0.
  - If pending is set: apply V(staging). On pass, copy staging to the shadow; on fail, set o_err and keep the old shadow. Clear pending either way.
  - If i_num_pulses ≠ 0 and the new count = i_num_pulses: go to IDLE with o_done.
- RUN and i_abort:
  - If i_sinc = 0: go to IDLE with o_done.
  - Else go to DRAIN.
- DRAIN: o_start held 1. On pulse end: increment the counter, then go to IDLE with o_done. Pending updates are discarded.
- i_cfg_update in CHECK/RUN/DRAIN: latch the inputs into staging and set pending. A later update overwrites staging.
- i_arm while busy is ignored. A second i_abort in DRAIN is ignored.
- Simultaneous events:
  - i_cfg_update and pulse end in the same cycle: the pulse end consumes the old staging; the new values become pending for the next gap.
  - i_abort and the terminal pulse end in the same cycle: normal completion, single o_done.

## Timing
- Reset values: o_start = 0, all shadow outputs = 0, o_busy = 0, o_done = 0, o_err = 0, o_pulse_cnt = 0, state = IDLE, pending = 0.
- All outputs are registered.
- i_arm sampled at edge k:
  - shadow outputs and o_busy update at k;
  - o_start = 1 from edge k+1.
- Pulse end detected in cycle c: shadow, count, o_done and o_start = 0 update at edge c+1.
- Because prt > period, o_start falls before the next sync rising edge.
- Reset asserted mid-burst: o_start drops immediately; the sync generator is reset by the same net.

## Structure
- Package tx_pkg holds:
  - the state enum (IDLE, CHECK, RUN, DRAIN);
  - a config struct {phase, period, prt, codigo, numdig, tb};
  - constant MAX_NUMDIG = 32.
- Sub-module tx_cfg_check: combinational V(cfg), instantiated twice, once for the shadow path and once for the staging path.

## Test plan
- Burst: period = 100, prt = 1000, numdig = 13, tb = 5, N = 3, i_arm → o_start rises 1 cycle after arm, 3 pulse ends, o_pulse_cnt = 3, o_done once, o_start = 0 before a 4th sync rise.
- Invalid config: prt = 100, period = 100, i_arm → o_err = 1, o_start never asserts, back to IDLE, no o_done.
- Live update: N = 0, i_cfg_update with phase 0x1000 mid-pulse → o_phase changes exactly 1 cycle after that pulse's sync fall, never during sync high.
- Abort during sync high → o_start held until sync falls, then 0, o_done once, count includes that pulse. Abort during sync low → IDLE next cycle.
- Bad update: staging numdig = 40 during RUN → o_err = 1, shadow unchanged, burst continues.
- Async reset mid-RUN → all outputs 0 without waiting for a clock edge; a new arm after release works normally.
